// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with fill level, almost flags, optional
// first-word-fall-through read, synchronous flush and sticky error flags.
module sync_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int SIZE      = 8,
    parameter int PTR_LEN   = $clog2(SIZE),
    parameter bit FWFT      = 1'b0,
    parameter int AFULL_TH  = SIZE - 2,
    parameter int AEMPTY_TH = 1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             flush,
    input  logic             w_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             r_en,
    output logic [WIDTH-1:0] data_out,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [PTR_LEN:0] level,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int LVL_W = PTR_LEN + 1;
    localparam logic [PTR_LEN:0] SIZE_LV   = LVL_W'(SIZE);
    localparam logic [PTR_LEN:0] AFULL_LV  = LVL_W'(AFULL_TH);
    localparam logic [PTR_LEN:0] AEMPTY_LV = LVL_W'(AEMPTY_TH);

    logic [WIDTH-1:0]   mem [SIZE];
    logic [PTR_LEN-1:0] wp;
    logic [PTR_LEN-1:0] rp;
    logic               rd_acc;
    logic               wr_acc;
    logic               ov_set;
    logic               uf_set;

    // Flags depend only on the level register, never on same-cycle requests.
    assign full         = (level == SIZE_LV);
    assign empty        = (level == '0);
    assign almost_full  = (level >= AFULL_LV);
    assign almost_empty = (level <= AEMPTY_LV);

    // A write into a full FIFO is only legal when a read frees a slot.
    assign rd_acc = r_en & ~empty & ~flush;
    assign wr_acc = w_en & ~flush & (~full | rd_acc);
    assign ov_set = w_en & full & ~rd_acc & ~flush;
    assign uf_set = r_en & empty & ~flush;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wp] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (wr_acc) begin
                wp <= wp + 1'b1;
            end
            if (rd_acc) begin
                rp <= rp + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ov_set | (overflow & ~clr_err);
            underflow <= uf_set | (underflow & ~clr_err);
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Gated by empty so the output reads zero out of reset.
            assign data_out = empty ? '0 : mem[rp];
            assign rd_valid = ~empty;
        end else begin : g_std
            logic [WIDTH-1:0] data_q;
            logic             valid_q;

            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_acc;
                    if (rd_acc) begin
                        data_q <= mem[rp];
                    end
                end
            end

            assign data_out = data_q;
            assign rd_valid = valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench: standard-mode FIFO checked through a read-data queue,
// plus a FWFT instance checked with directed vectors.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       flush, w_en, r_en, clr_err;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       rd_valid, full, empty, almost_full, almost_empty;
    logic [3:0] level;
    logic       overflow, underflow;

    logic       wb, rb, flush_b, clr_b;
    logic [7:0] db;
    logic [7:0] data_out_b;
    logic       rd_valid_b, full_b, empty_b, afull_b, aempty_b;
    logic [3:0] level_b;
    logic       ov_b, uf_b;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    sync_fifo_param #(.WIDTH(8), .SIZE(8), .FWFT(1'b0)) dut_std (
        .clk(clk), .arst_n(arst_n), .flush(flush), .w_en(w_en), .data_in(data_in),
        .r_en(r_en), .data_out(data_out), .rd_valid(rd_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .level(level), .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    sync_fifo_param #(.WIDTH(8), .SIZE(8), .FWFT(1'b1)) dut_fwft (
        .clk(clk), .arst_n(arst_n), .flush(flush_b), .w_en(wb), .data_in(db),
        .r_en(rb), .data_out(data_out_b), .rd_valid(rd_valid_b), .full(full_b),
        .empty(empty_b), .almost_full(afull_b), .almost_empty(aempty_b),
        .level(level_b), .overflow(ov_b), .underflow(uf_b), .clr_err(clr_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rd_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (rd_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got 0x%0h want no read", data_out);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if (data_out !== e) begin
                    bad++;
                    $display("FAIL sb_data: got 0x%0h want 0x%0h at %0t", data_out, e, $time);
                end
            end
        end
    end

    task automatic check_reset(input string nm);
        chk({nm, "_dout"}, 32'(data_out), 32'h0);
        chk({nm, "_rvalid"}, 32'(rd_valid), 32'h0);
        chk({nm, "_level"}, 32'(level), 32'h0);
        chk({nm, "_empty"}, 32'(empty), 32'h1);
        chk({nm, "_full"}, 32'(full), 32'h0);
        chk({nm, "_aempty"}, 32'(almost_empty), 32'h1);
        chk({nm, "_afull"}, 32'(almost_full), 32'h0);
        chk({nm, "_ovf"}, 32'(overflow), 32'h0);
        chk({nm, "_udf"}, 32'(underflow), 32'h0);
        chk({nm, "_fwft_rvalid"}, 32'(rd_valid_b), 32'h0);
        chk({nm, "_fwft_dout"}, 32'(data_out_b), 32'h0);
    endtask

    initial begin
        arst_n = 1'b0; flush = 1'b0; w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; data_in = '0;
        wb = 1'b0; rb = 1'b0; flush_b = 1'b0; clr_b = 1'b0; db = '0;
        #12;
        check_reset("rst");
        cyc();
        arst_n = 1'b1;
        cyc();

        // Fill 0x11..0x88; almost_full from the 6th write
        for (int i = 1; i <= 8; i++) begin
            w_en = 1'b1; data_in = 8'(i * 8'h11);
            cyc();
            chk("fill_level", 32'(level), 32'(i));
            chk("fill_afull", 32'(almost_full), 32'(i >= 6));
            chk("fill_full", 32'(full), 32'(i == 8));
            chk("fill_aempty", 32'(almost_empty), 32'(i <= 1));
        end
        data_in = 8'h99;
        cyc();
        w_en = 1'b0;
        chk("ovf_set", 32'(overflow), 32'h1);
        chk("ovf_level", 32'(level), 32'd8);

        // Drain; one extra read underflows
        r_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            sb.push_back(8'(i * 8'h11));
            cyc();
            chk("drain_level", 32'(level), 32'(8 - i));
        end
        chk("drain_empty", 32'(empty), 32'h1);
        cyc();
        r_en = 1'b0;
        chk("udf_set", 32'(underflow), 32'h1);
        chk("udf_rvalid", 32'(rd_valid), 32'h0);
        chk("udf_dout_hold", 32'(data_out), 32'h88);
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'h0);
        chk("clr_udf", 32'(underflow), 32'h0);

        // Sustained read+write at level 4, pointers wrap
        w_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in = 8'(i);
            cyc();
        end
        r_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            data_in = 8'(4 + k);
            sb.push_back(8'(k));
            cyc();
            chk("stream_level", 32'(level), 32'd4);
        end
        w_en = 1'b0;
        for (int k = 20; k < 24; k++) begin
            sb.push_back(8'(k));
            cyc();
        end
        r_en = 1'b0;
        cyc();
        chk("stream_empty", 32'(empty), 32'h1);

        // Simultaneous read/write while full
        w_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = 8'(8'hA0 + i);
            cyc();
        end
        r_en = 1'b1; data_in = 8'hB0;
        sb.push_back(8'hA0);
        cyc();
        w_en = 1'b0;
        chk("full_rw_level", 32'(level), 32'd8);
        chk("full_rw_ovf", 32'(overflow), 32'h0);
        for (int i = 1; i < 8; i++) begin
            sb.push_back(8'(8'hA0 + i));
            cyc();
        end
        sb.push_back(8'hB0);
        cyc();
        r_en = 1'b0;
        cyc();

        // Flush at level 5 with both errors set
        r_en = 1'b1;
        cyc();
        r_en = 1'b0;
        w_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            data_in = 8'(8'hC0 + i);
            cyc();
        end
        w_en = 1'b0;
        chk("pre_flush_ovf", 32'(overflow), 32'h1);
        chk("pre_flush_udf", 32'(underflow), 32'h1);
        r_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(8'(8'hC0 + i));
            cyc();
        end
        chk("pre_flush_level", 32'(level), 32'd5);
        flush = 1'b1; w_en = 1'b1; data_in = 8'hEE;
        cyc();
        flush = 1'b0; w_en = 1'b0; r_en = 1'b0;
        chk("flush_level", 32'(level), 32'h0);
        chk("flush_empty", 32'(empty), 32'h1);
        chk("flush_rvalid", 32'(rd_valid), 32'h0);
        chk("flush_dout", 32'(data_out), 32'hC2);
        chk("flush_ovf", 32'(overflow), 32'h1);
        chk("flush_udf", 32'(underflow), 32'h1);
        clr_err = 1'b1;
        cyc();
        chk("flush_clr_ovf", 32'(overflow), 32'h0);
        chk("flush_clr_udf", 32'(underflow), 32'h0);
        r_en = 1'b1;
        cyc();
        r_en = 1'b0; clr_err = 1'b0;
        chk("set_beats_clr", 32'(underflow), 32'h1);

        // Asynchronous reset mid-burst at level 3
        w_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = 8'(8'h31 + i);
            cyc();
        end
        chk("pre_rst_level", 32'(level), 32'd3);
        data_in = 8'h34;
        #3;
        arst_n = 1'b0;
        #1;
        w_en = 1'b0;
        check_reset("arst");
        cyc();
        arst_n = 1'b1;
        w_en = 1'b1; data_in = 8'h3C;
        cyc();
        w_en = 1'b0;
        chk("post_rst_level", 32'(level), 32'd1);
        r_en = 1'b1;
        sb.push_back(8'h3C);
        cyc();
        r_en = 1'b0;
        cyc();
        chk("post_rst_empty", 32'(empty), 32'h1);

        // FWFT instance
        wb = 1'b1; db = 8'hA5;
        cyc();
        wb = 1'b0;
        chk("fwft_dout", 32'(data_out_b), 32'hA5);
        chk("fwft_rvalid", 32'(rd_valid_b), 32'h1);
        rb = 1'b1;
        cyc();
        rb = 1'b0;
        chk("fwft_pop_empty", 32'(empty_b), 32'h1);
        chk("fwft_pop_rvalid", 32'(rd_valid_b), 32'h0);
        wb = 1'b1; db = 8'h5A;
        cyc();
        db = 8'h6B;
        cyc();
        wb = 1'b0;
        chk("fwft_head", 32'(data_out_b), 32'h5A);
        rb = 1'b1;
        cyc();
        rb = 1'b0;
        chk("fwft_next", 32'(data_out_b), 32'h6B);
        chk("fwft_level", 32'(level_b), 32'd1);

        cyc();
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, parametrised FIFO for the MAC datapath, used where producer and consumer share one clock (e.g. TX staging ahead of the framer, RX buffering behind the CRC checker). It extends the async FIFO family with a run-time fill level, programmable almost-full/almost-empty thresholds, a selectable first-word-fall-through (FWFT) read mode, synchronous flush, and sticky overflow/underflow error flags.

## Interface
- WIDTH, 8: data word width in bits.
- SIZE, 8: depth in words; power of two, ≥ 2.
- PTR_LEN, $clog2(SIZE): pointer width.
- FWFT, 0: 0 = standard registered read, 1 = first-word-fall-through.
- AFULL_TH, SIZE-2: almost_full asserted when level ≥ AFULL_TH; range 1..SIZE.
- AEMPTY_TH, 1: almost_empty asserted when level ≤ AEMPTY_TH; range 0..SIZE-1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- arst_n  in  1  asynchronous active-low reset. Assertion is asynchronous; deassertion takes effect on the next clk edge.
- flush  in  1  synchronous clear of contents.
- w_en  in  1  write request.
- data_in  in  WIDTH  write data.
- r_en  in  1  read request (FWFT: pop).
- data_out  out  WIDTH  read data.
- rd_valid  out  1  data_out valid qualifier.
- full  out  1  level == SIZE.
- empty  out  1  level == 0.
- almost_full  out  1  level ≥ AFULL_TH.
- almost_empty  out  1  level ≤ AEMPTY_TH.
- level  out  PTR_LEN+1  words stored, 0..SIZE.
- overflow  out  1  sticky: write rejected.
- underflow  out  1  sticky: read rejected.
- clr_err  in  1  synchronous clear of overflow/underflow.

## Operation
- Storage: SIZE×WIDTH register array. Write pointer wp and read pointer rp are PTR_LEN bits wide and wrap SIZE-1 → 0 naturally. level is a separate counter.
- Read accept: rd_acc = r_en & !empty & !flush.
- Write accept: wr_acc = w_en & !flush & (!full | rd_acc). A write while full is accepted only when a read is accepted in the same cycle.
- No write-to-read bypass. A read while empty is rejected even if a write occurs in the same cycle.
- Level update: +1 on wr_acc only, −1 on rd_acc only, unchanged on both or neither.
- Flags full, empty, almost_full, almost_empty are combinational from the level register only; they never depend on same-cycle requests.
- Standard mode (FWFT=0):
  - rd_acc registers mem[rp] into data_out and pulses rd_valid high for exactly one cycle after the accepted edge.
  - data_out holds its last value otherwise.
- FWFT mode:
  - data_out = mem[rp] combinationally; rd_valid = !empty.
  - rd_acc advances rp, so the next word appears in the same cycle as the pointer update.
- Errors:
  - overflow is set on w_en & full & !rd_acc & !flush.
  - underflow is set on r_en & empty & !flush.
  - Both are sticky until clr_err or reset. If clr_err coincides with a new error in the same cycle, the set wins.
- flush:
  - Has priority over w_en and r_en.
  - On the next edge, wp, rp and level go to 0 and rd_valid goes to 0.
  - data_out, memory contents and the error flags are unchanged.
- Reset mid-operation discards all contents, with the same effect as flush plus the reset values below. Memory contents need not be cleared.

## Timing
- Reset values: data_out 0, rd_valid 0, level 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0.
- Write → visibility:
  - level, empty and almost flags update at the edge that accepts the write.
  - FWFT: data_out is valid in the cycle after the write into an empty FIFO.
  - Standard mode: the earliest read is accepted in the cycle after the write, with data one cycle after that.
- Read latency: 1 cycle in standard mode, 0 cycles in FWFT mode.
- Sustained simultaneous read/write at any non-empty level gives 1 word/cycle throughput with level constant, including at full.
- Wrap-around: after SIZE writes and SIZE reads, pointers return to 0 with no data corruption across the wrap.

## Test plan
- Reset, then 8 writes of 0x11..0x88 (SIZE=8, FWFT=0):
  - full=1 and level=8 after the 8th edge; almost_full first seen after the 6th write.
  - 9th write (0x99) sets overflow; level stays 8.
- From full, 8 reads:
  - data_out sequence is 0x11..0x88, each value with a one-cycle rd_valid pulse one cycle after r_en.
  - empty=1 at end; a 9th read sets underflow and data_out holds 0x88.
- Level 4, w_en=r_en=1 for 20 cycles with incrementing data: level stays 4 throughout, output is in order, and pointers wrap twice. At full, simultaneous read/write is accepted without overflow.
- FWFT=1: write 0xA5 into empty FIFO → next cycle data_out=0xA5 and rd_valid=1. Pulse r_en → empty=1 and rd_valid=0 the following cycle.
- Level 5, flush together with w_en and r_en:
  - Next cycle level=0 and empty=1; overflow and underflow unchanged.
  - clr_err clears the sticky flags one cycle later.
- arst_n low mid-burst at level 3: outputs reach their reset values immediately (asynchronously). After release, the first write is 0x3C, then a read returns 0x3C.
